// File: rtl/rca_accumulator_pkg.sv
// Shared constants for the ripple-carry adder family: datapath width,
// operand counter width and accumulator state encoding.
package rca_accumulator_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/rca_accumulator_rca.sv
// 32-bit ripple-carry adder built from a chain of full-adder cells.
module thirty_two_bit_RCA
   import rca_accumulator_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   output logic [DATA_W-1:0] sum,
   output logic              cout
);

   logic [DATA_W:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[DATA_W];

endmodule

// File: rtl/rca_accumulator.sv
// Block accumulator: sums up to MAX_TERMS unsigned operands through a
// ripple-carry adder and holds the result until the consumer takes it.
module rca_accumulator
   import rca_accumulator_pkg::*;
#(
   parameter int unsigned MAX_TERMS = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_sum,
   output logic              out_ovf,
   output logic [CNT_W-1:0]  out_count
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              rdy_q, rdy_d;

   logic [DATA_W-1:0] add_sum;
   logic              add_cout;
   logic [CNT_W-1:0]  count_inc;
   logic              accept;
   logic              close_blk;
   logic              release_blk;

   thirty_two_bit_RCA u_rca (
      .a    (acc_q),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // rdy_q keeps in_ready low until the first edge after reset releases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         count_q <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      count_inc   = count_q + 8'd1;
      accept      = in_valid & in_ready;
      close_blk   = in_last | (count_inc == MAX_CNT);
      release_blk = (state_q == HOLD) & out_ready;
      rdy_d       = 1'b1;

      state_d = state_q;
      unique case (state_q)
         IDLE, ACCUM: if (accept) state_d = close_blk ? HOLD : ACCUM;
         HOLD:        if (out_ready) state_d = IDLE;
         default:     state_d = IDLE;
      endcase

      acc_d   = acc_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      if (release_blk) begin
         acc_d   = '0;
         ovf_d   = 1'b0;
         count_d = '0;
      end else if (accept) begin
         acc_d   = add_sum;
         ovf_d   = ovf_q | add_cout;
         count_d = count_inc;
      end
   end

   always_comb begin
      in_ready  = rdy_q & ((state_q == IDLE) | (state_q == ACCUM));
      out_valid = (state_q == HOLD);
      out_sum   = acc_q;
      out_ovf   = ovf_q;
      out_count = count_q;
   end

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed bench for rca_accumulator: a 16-term and a 1-term instance share
// stimulus and are checked every cycle against a transaction-level model.
module tb_rca_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data = '0;

   logic        in_ready0, out_valid0, out_ovf0;
   logic [31:0] out_sum0;
   logic [7:0]  out_count0;
   logic        in_ready1, out_valid1, out_ovf1;
   logic [31:0] out_sum1;
   logic [7:0]  out_count1;

   int tests = 0;
   int fails = 0;

   rca_accumulator #(.MAX_TERMS(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
      .out_ready(out_ready), .out_sum(out_sum0), .out_ovf(out_ovf0),
      .out_count(out_count0)
   );

   rca_accumulator #(.MAX_TERMS(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
      .out_ready(out_ready), .out_sum(out_sum1), .out_ovf(out_ovf1),
      .out_count(out_count1)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              hold;
      bit              rdy;
      bit              ovf;
      int unsigned     cnt;
      longint unsigned sum;
   } mdl_t;

   mdl_t m [2];

   function automatic mdl_t mstep(mdl_t c, int unsigned maxt);
      mdl_t n = c;
      if (c.hold && out_ready) begin
         n.hold = 0; n.ovf = 0; n.cnt = 0; n.sum = 0;
      end else if (c.rdy && !c.hold && in_valid) begin
         n.sum = c.sum + 64'(in_data);
         if (n.sum >= 64'h1_0000_0000) begin
            n.sum -= 64'h1_0000_0000;
            n.ovf = 1;
         end
         n.cnt = c.cnt + 1;
         if (in_last || n.cnt == maxt) n.hold = 1;
      end
      n.rdy = 1;
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m[0] <= '{default: 0};
         m[1] <= '{default: 0};
      end else begin
         m[0] <= mstep(m[0], 16);
         m[1] <= mstep(m[1], 1);
      end
   end

   function automatic logic [42:0] pk(bit r, bit v, bit o, logic [7:0] cnt, logic [31:0] s);
      return {r, v, o, cnt, s};
   endfunction

   function automatic logic [42:0] exp_of(mdl_t c);
      return pk(c.rdy && !c.hold, c.hold, c.ovf, 8'(c.cnt), 32'(c.sum));
   endfunction

   function automatic logic [42:0] obs(int k);
      if (k == 0) return {in_ready0, out_valid0, out_ovf0, out_count0, out_sum0};
      return {in_ready1, out_valid1, out_ovf1, out_count1, out_sum1};
   endfunction

   task automatic chk(string name, logic [42:0] act, logic [42:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got rdy=%0b vld=%0b ovf=%0b cnt=%0d sum=%08h, want rdy=%0b vld=%0b ovf=%0b cnt=%0d sum=%08h",
                  name, act[42], act[41], act[40], act[39:32], act[31:0],
                  req[42], req[41], req[40], req[39:32], req[31:0]);
      end
   endtask

   always @(negedge clk) begin
      chk("model_d16", obs(0), exp_of(m[0]));
      chk("model_d1", obs(1), exp_of(m[1]));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(logic [31:0] d, logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      #2 rst = 1'b1;
      step();
      step();
      chk("reset_d16", obs(0), pk(0, 0, 0, 0, 0));
      chk("reset_d1", obs(1), pk(0, 0, 0, 0, 0));
      rst = 1'b0;
      step();
      chk("ready_after_rst", obs(0), pk(1, 0, 0, 0, 0));

      out_ready = 1'b1;
      beat(32'd5, 1'b0);
      chk("acc_first", obs(0), pk(1, 0, 0, 1, 5));
      beat(32'd7, 1'b0);
      beat(32'd9, 1'b1);
      chk("sum_5_7_9", obs(0), pk(0, 1, 0, 3, 21));
      in_valid = 1'b0;
      step();
      chk("idle_after_hs", obs(0), pk(1, 0, 0, 0, 0));

      out_ready = 1'b0;
      beat(32'hFFFF_FFFF, 1'b0);
      chk("pre_wrap", obs(0), pk(1, 0, 0, 1, 32'hFFFF_FFFF));
      beat(32'h0000_0002, 1'b1);
      chk("wrap", obs(0), pk(0, 1, 1, 2, 32'h0000_0001));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("wrap_cleared", obs(0), pk(1, 0, 0, 0, 0));

      in_valid = 1'b1;
      in_data  = 32'd1;
      in_last  = 1'b0;
      for (int i = 0; i < 16; i++) step();
      chk("auto_close", obs(0), pk(0, 1, 0, 16, 16));
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_stable", obs(0), pk(0, 1, 0, 16, 16));
      end
      out_ready = 1'b1;
      step();
      chk("hs_no_accept", obs(0), pk(1, 0, 0, 0, 0));
      out_ready = 1'b0;
      step();
      chk("beat17", obs(0), pk(1, 0, 0, 1, 1));
      in_last = 1'b1;
      step();
      chk("close_after_17", obs(0), pk(0, 1, 0, 2, 2));
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      beat(32'd10, 1'b0);
      beat(32'd20, 1'b0);
      in_valid = 1'b0;
      chk("two_beats", obs(0), pk(1, 0, 0, 2, 30));
      #2 rst = 1'b1;
      #1 chk("async_rst", obs(0), pk(0, 0, 0, 0, 0));
      step();
      rst = 1'b0;
      chk("rdy_low_after_rst", obs(0), pk(0, 0, 0, 0, 0));
      step();
      beat(32'd3, 1'b1);
      chk("after_rst_block", obs(0), pk(0, 1, 0, 1, 3));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();

      in_valid = 1'b1;
      in_data  = 32'd4;
      in_last  = 1'b0;
      step();
      chk("mt1_first", obs(1), pk(0, 1, 0, 1, 4));
      in_data = 32'd6;
      step();
      chk("mt1_gap", obs(1), pk(1, 0, 0, 0, 0));
      step();
      chk("mt1_second", obs(1), pk(0, 1, 0, 1, 6));
      chk("d16_during_mt1", obs(0), pk(1, 0, 0, 3, 16));
      in_valid = 1'b0;
      step();
      chk("mt1_done", obs(1), pk(1, 0, 0, 0, 0));
      out_ready = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
